// File: rtl/mano_pkg.sv
// mano_pkg: shared opcodes, FSM states, T-state constants and micro-op enable bundle
package mano_pkg;
  localparam logic [1:0] OP_NOP = 2'b00, OP_LDA = 2'b01, OP_MOVR = 2'b10, OP_HLT = 2'b11;
  typedef enum logic [1:0] {IDLE, EXEC, HALT, ERR} state_t;
  localparam logic [2:0] T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3,
                         T4 = 3'd4, T5 = 3'd5, T6 = 3'd6, T7 = 3'd7;
  typedef struct packed {
    logic ld_mar_pc;
    logic ld_mar_mbr;
    logic ld_mbr;
    logic inc_pc;
    logic ld_ir;
    logic ld_a_mbr;
    logic ld_a_r;
  } uops_t;
  function automatic logic is_read(input logic [2:0] t);
    return t == T1 || t == T4 || t == T6;
  endfunction
endpackage

// File: rtl/mano_mem_wait.sv
// mano_mem_wait: counts cycles of an outstanding read and flags ack or timeout
module mano_mem_wait #(
  parameter int TIMEOUT = 15
) (
  input  logic SysClk,
  input  logic rst_n,
  input  logic active,
  input  logic mem_ack,
  output logic done,
  output logic timeout
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign done    = active && mem_ack;
  assign timeout = active && !mem_ack && cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge SysClk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (active && !done) ? cnt + 1'b1 : '0;
endmodule

// File: rtl/mano_control_sequencer.sv
// mano_control_sequencer: T-state control unit for the 8-bit accumulator datapath.
// Define MANO_SINGLE_STEP_EN to add the step input for single-instruction execution.
module mano_control_sequencer
  import mano_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int TW      = 3
) (
  input  logic          SysClk,
  input  logic          rst_n,
  input  logic          run,
`ifdef MANO_SINGLE_STEP_EN
  input  logic          step,
`endif
  input  logic [1:0]    ir_op,
  input  logic          mem_ack,
  output logic          mem_req,
  output logic          ld_mar_pc,
  output logic          ld_mar_mbr,
  output logic          ld_mbr,
  output logic          inc_pc,
  output logic          ld_ir,
  output logic          ld_a_mbr,
  output logic          ld_a_r,
  output logic [TW-1:0] t_state,
  output logic          halted,
  output logic          mem_err
);
  state_t st;
  uops_t  u;
  logic   ex, rd, done, timeout, go, eoi;
`ifdef MANO_SINGLE_STEP_EN
  logic [2:0] step_q;
  always_ff @(posedge SysClk or negedge rst_n)
    if (!rst_n) step_q <= '0;
    else step_q <= {step_q[1:0], step};
  assign go = run || (step_q[1] && !step_q[2]);
`else
  assign go = run;
`endif
  assign ex      = st == EXEC;
  assign rd      = ex && is_read(t_state);
  assign mem_req = rd;
  mano_mem_wait #(.TIMEOUT(TIMEOUT)) u_wait (
    .SysClk (SysClk),
    .rst_n  (rst_n),
    .active (rd),
    .mem_ack(mem_ack),
    .done   (done),
    .timeout(timeout)
  );
  // ld_mbr/inc_pc fire in the ack cycle itself so the read state ends on that edge
  always_comb begin
    u            = '0;
    u.ld_mar_pc  = ex && (t_state == T0 || (t_state == T3 && ir_op == OP_LDA));
    u.ld_mar_mbr = ex && t_state == T5;
    u.ld_mbr     = done;
    u.inc_pc     = done && t_state != T6;
    u.ld_ir      = ex && t_state == T2;
    u.ld_a_mbr   = ex && t_state == T7;
    u.ld_a_r     = ex && t_state == T3 && ir_op == OP_MOVR;
  end
  assign {ld_mar_pc, ld_mar_mbr, ld_mbr, inc_pc, ld_ir, ld_a_mbr, ld_a_r} = u;
  assign eoi = t_state == T7 || (t_state == T3 && (ir_op == OP_NOP || ir_op == OP_MOVR));
  always_ff @(posedge SysClk or negedge rst_n)
    if (!rst_n) begin
      st      <= IDLE;
      t_state <= '0;
      halted  <= 1'b0;
      mem_err <= 1'b0;
    end else begin
      case (st)
        IDLE: if (go) begin
          st      <= EXEC;
          t_state <= T0;
        end
        EXEC: if (timeout) begin
          st      <= ERR;
          mem_err <= 1'b1;
        end else if (t_state == T3 && ir_op == OP_HLT) begin
          st     <= HALT;
          halted <= 1'b1;
        end else if (eoi) begin
          st      <= run ? EXEC : IDLE;
          t_state <= T0;
        end else if (!rd || done) t_state <= t_state + 1'b1;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_mano_control_sequencer.sv
// tb_mano_control_sequencer: directed checks with a small datapath and memory model
module tb_mano_control_sequencer;
  logic SysClk = 0, rst_n = 0, run = 0, mem_ack, stray = 0, dp_clr = 1;
`ifdef MANO_SINGLE_STEP_EN
  logic step = 0;
`endif
  logic mem_req, ld_mar_pc, ld_mar_mbr, ld_mbr, inc_pc, ld_ir, ld_a_mbr, ld_a_r, halted, mem_err;
  logic [2:0] t_state;
  logic [7:0] mem [256];
  logic [7:0] mar, mbr, pc, ir, a, r;
  logic [6:0] en;
  int ack_delay = 1, wcnt, n_mbr, n_ir, n_en, viol, vec, errs, n0, n1;

  always #5 SysClk = ~SysClk;

  mano_control_sequencer dut (
    .SysClk(SysClk), .rst_n(rst_n), .run(run),
`ifdef MANO_SINGLE_STEP_EN
    .step(step),
`endif
    .ir_op(ir[1:0]), .mem_ack(mem_ack), .mem_req(mem_req),
    .ld_mar_pc(ld_mar_pc), .ld_mar_mbr(ld_mar_mbr), .ld_mbr(ld_mbr), .inc_pc(inc_pc),
    .ld_ir(ld_ir), .ld_a_mbr(ld_a_mbr), .ld_a_r(ld_a_r),
    .t_state(t_state), .halted(halted), .mem_err(mem_err)
  );

  assign en = {ld_mar_pc, ld_mar_mbr, ld_mbr, inc_pc, ld_ir, ld_a_mbr, ld_a_r};
  assign mem_ack = stray || (mem_req && ack_delay != 0 && wcnt == ack_delay - 1);

  always @(posedge SysClk) begin
    wcnt <= (dp_clr || !mem_req) ? 0 : wcnt + 1;
    if (dp_clr) begin
      mar <= 0; mbr <= 0; pc <= 0; ir <= 0; a <= 0;
    end else begin
      if (ld_mar_pc) mar <= pc;
      if (ld_mar_mbr) mar <= mbr;
      if (ld_mbr) mbr <= mem[mar];
      if (inc_pc) pc <= pc + 8'd1;
      if (ld_ir) ir <= mbr;
      if (ld_a_mbr) a <= mbr;
      if (ld_a_r) a <= r;
    end
    if (ld_mbr) n_mbr <= n_mbr + 1;
    if (ld_ir) n_ir <= n_ir + 1;
    if (en != 0) n_en <= n_en + 1;
  end

  always @(negedge SysClk)
    if ((32'(ld_mar_pc) + 32'(ld_mar_mbr) + 32'(ld_mbr) + 32'(ld_ir) + 32'(ld_a_mbr) + 32'(ld_a_r)) > 1
        || (inc_pc && !ld_mbr)) viol <= viol + 1;

  task automatic tick;
    @(posedge SysClk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 0; dp_clr = 1; run = 0; stray = 0;
    tick; tick;
    rst_n = 1; dp_clr = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    r = 8'h5A;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    do_reset;
    chk("rst_t", 32'(t_state), 0);
    chk("rst_en", 32'(en), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_halt", 32'(halted), 0);
    chk("rst_err", 32'(mem_err), 0);
    // MOVR with single-cycle ack
    mem[0] = 8'h02; run = 1;
    tick; chk("movr_t0", {t_state, en}, {3'd0, 7'b1000000});
    tick; chk("movr_t1", {t_state, en}, {3'd1, 7'b0011000});
    tick; chk("movr_t2", {t_state, en}, {3'd2, 7'b0000100});
    tick; chk("movr_t3", {t_state, en}, {3'd3, 7'b0000001});
    tick; chk("movr_next", {t_state, en}, {3'd0, 7'b1000000});
    chk("movr_a", 32'(a), 32'h5A);
    chk("movr_pc", 32'(pc), 1);
    // LDA, stray ack at T2, run dropped at T5
    do_reset;
    mem[0] = 8'h01; mem[1] = 8'h06; mem[6] = 8'hC3; n0 = n_mbr; run = 1;
    tick; tick; tick;
    stray = 1; #1;
    chk("stray_ack", {t_state, en}, {3'd2, 7'b0000100});
    stray = 0;
    tick; chk("lda_t3", {t_state, en}, {3'd3, 7'b1000000});
    tick; chk("lda_t4", {t_state, en}, {3'd4, 7'b0011000});
    tick; chk("lda_t5", {t_state, en}, {3'd5, 7'b0100000});
    run = 0;
    tick; chk("lda_t6", {t_state, en}, {3'd6, 7'b0010000});
    tick; chk("lda_t7", {t_state, en}, {3'd7, 7'b0000010});
    tick; chk("lda_idle", {t_state, en}, {3'd0, 7'b0000000});
    chk("lda_a", 32'(a), 32'hC3);
    chk("lda_pc", 32'(pc), 2);
    chk("lda_nmbr", 32'(n_mbr - n0), 3);
    tick; chk("lda_idle2", {t_state, en, mem_req}, 0);
    // ack arriving on the fifth request cycle
    do_reset;
    ack_delay = 5; n0 = n_mbr; run = 1;
    tick;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("wait_t", 32'(t_state), 1);
      chk("wait_req", 32'(mem_req), 1);
    end
    tick; chk("wait_t2", 32'(t_state), 2);
    chk("wait_nmbr", 32'(n_mbr - n0), 1);
    // no ack: timeout
    do_reset;
    ack_delay = 0; run = 1;
    tick;
    repeat (15) tick;
    chk("to_last", {t_state, mem_req, mem_err}, {3'd1, 1'b1, 1'b0});
    tick; chk("to_err", {mem_req, mem_err}, {1'b1 ^ 1'b1, 1'b1});
    n0 = n_en;
    repeat (5) tick;
    chk("to_quiet", 32'(n_en - n0), 0);
    chk("to_sticky", 32'(mem_err), 1);
    do_reset;
    chk("to_cleared", 32'(mem_err), 0);
    // asynchronous reset mid-read
    run = 1;
    tick; tick;
    chk("ar_req", 32'(mem_req), 1);
    #3 rst_n = 0;
    #1 chk("ar_drop", {t_state, mem_req}, 0);
    // HLT
    do_reset;
    ack_delay = 1; mem[0] = 8'h03; run = 1;
    repeat (4) tick;
    chk("hlt_t3", {t_state, en, halted}, {3'd3, 7'b0, 1'b0});
    tick; chk("hlt_set", {halted, en, mem_req}, {1'b1, 7'b0, 1'b0});
    n0 = n_en;
    repeat (6) tick;
    chk("hlt_quiet", 32'(n_en - n0), 0);
    chk("hlt_hold", 32'(halted), 1);
`ifdef MANO_SINGLE_STEP_EN
    // single step: NOP at 0, LDA 6 at 1, step edge during T4 ignored
    do_reset;
    mem[0] = 8'h00; mem[1] = 8'h01; mem[2] = 8'h06; mem[6] = 8'hC3; n1 = n_ir;
    step = 1; tick; step = 0;
    repeat (10) tick;
    chk("step1_nir", 32'(n_ir - n1), 1);
    chk("step1_idle", {t_state, en}, 0);
    step = 1; tick; step = 0;
    for (int k = 0; k < 20 && t_state != 3'd4; k++) tick;
    chk("step2_t4", 32'(t_state), 4);
    step = 1; tick; step = 0;
    repeat (15) tick;
    chk("step2_nir", 32'(n_ir - n1), 2);
    chk("step2_a", 32'(a), 32'hC3);
    chk("step2_pc", 32'(pc), 3);
    chk("step2_idle", {t_state, en}, 0);
`endif
    chk("one_hot", 32'(viol), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
